// File: rtl/bist_pattern_controller_if.sv
// Session control and status bundle between the BIST pattern controller and its host/MISR side.
interface bist_pattern_controller_if;
  logic        start;
  logic        abort;
  logic        pass_nfail_in;
  logic        scan_in;
  logic        scan_enable;
  logic        test_mode;
  logic        misr_reset;
  logic        misr_enable;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] pattern_count;

  modport master (
    output start, abort, pass_nfail_in,
    input  scan_in, scan_enable, test_mode, misr_reset, misr_enable,
    input  busy, done, pass, pattern_count
  );

  modport slave (
    input  start, abort, pass_nfail_in,
    output scan_in, scan_enable, test_mode, misr_reset, misr_enable,
    output busy, done, pass, pattern_count
  );
endinterface

// File: rtl/bist_pattern_controller.sv
// Logic-BIST sequencer for one scan chain: Galois LFSR patterns, shift/capture/unload FSM,
// MISR reset/enable control and latched pass/fail result.
module bist_pattern_controller #(
  parameter int unsigned CHAIN_LEN    = 32,
  parameter int unsigned NUM_PATTERNS = 100,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                         clock,
  input  logic                         reset,
  bist_pattern_controller_if.slave     bus
);

  localparam int unsigned CNT_W      = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [15:0] PAT_TOTAL  = 16'(NUM_PATTERNS);
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_SHIFT, ST_CAPTURE, ST_UNLOAD, ST_CHECK, ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [15:0]      pat_cnt_q, pat_cnt_d;
  logic             pass_q, pass_d;
  logic [15:0]      lfsr_adv;

  logic scan_in_q, scan_enable_q, misr_reset_q, misr_enable_q, busy_q, done_q;

  assign lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  // Next-state, counter and LFSR logic; abort overrides every transition.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    pass_d      = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          // Session state is reloaded on acceptance so INIT already shows a clean slate.
          state_d     = ST_INIT;
          lfsr_d      = LFSR_SEED;
          shift_cnt_d = '0;
          pat_cnt_d   = '0;
          pass_d      = 1'b0;
        end
      end
      ST_INIT: begin
        state_d     = ST_SHIFT;
        lfsr_d      = LFSR_SEED;
        shift_cnt_d = '0;
        pat_cnt_d   = '0;
      end
      ST_SHIFT: begin
        lfsr_d = lfsr_adv;
        if (shift_cnt_q == SHIFT_LAST) begin
          shift_cnt_d = '0;
          state_d     = ST_CAPTURE;
        end else begin
          shift_cnt_d = shift_cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        pat_cnt_d = pat_cnt_q + 16'd1;
        state_d   = (pat_cnt_q + 16'd1 == PAT_TOTAL) ? ST_UNLOAD : ST_SHIFT;
      end
      ST_UNLOAD: begin
        if (shift_cnt_q == SHIFT_LAST) begin
          shift_cnt_d = '0;
          state_d     = ST_CHECK;
        end else begin
          shift_cnt_d = shift_cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        pass_d  = bus.pass_nfail_in;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort) begin
      state_d     = ST_IDLE;
      lfsr_d      = LFSR_SEED;
      shift_cnt_d = '0;
      pat_cnt_d   = '0;
      pass_d      = 1'b0;
    end
  end

  // State register; outputs are registered decodes of the next state so they track state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      lfsr_q        <= LFSR_SEED;
      shift_cnt_q   <= '0;
      pat_cnt_q     <= '0;
      pass_q        <= 1'b0;
      scan_in_q     <= 1'b0;
      scan_enable_q <= 1'b0;
      misr_reset_q  <= 1'b0;
      misr_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      shift_cnt_q   <= shift_cnt_d;
      pat_cnt_q     <= pat_cnt_d;
      pass_q        <= pass_d;
      scan_in_q     <= (state_d == ST_SHIFT) && lfsr_d[0];
      scan_enable_q <= (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
      misr_reset_q  <= (state_d == ST_INIT);
      // First load has unknown chain contents, so nothing is compacted then.
      misr_enable_q <= ((state_d == ST_SHIFT) && (pat_cnt_d != 16'd0)) || (state_d == ST_UNLOAD);
      busy_q        <= (state_d == ST_INIT) || (state_d == ST_SHIFT) || (state_d == ST_CAPTURE) ||
                       (state_d == ST_UNLOAD) || (state_d == ST_CHECK);
      done_q        <= (state_d == ST_DONE);
    end
  end

  assign bus.scan_in       = scan_in_q;
  assign bus.scan_enable   = scan_enable_q;
  assign bus.test_mode     = busy_q;
  assign bus.misr_reset    = misr_reset_q;
  assign bus.misr_enable   = misr_enable_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.pattern_count = pat_cnt_q;

endmodule

// File: tb/tb_bist_pattern_controller.sv
// Directed bench for bist_pattern_controller with CHAIN_LEN=4, NUM_PATTERNS=2, default seed.
module tb_bist_pattern_controller;

  logic clock = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clock = ~clock;

  bist_pattern_controller_if bus ();

  bist_pattern_controller #(
    .CHAIN_LEN    (4),
    .NUM_PATTERNS (2),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // {scan_in, misr_reset, scan_enable, misr_enable, busy, done} per cycle after INIT entry
  logic [5:0] exp_ctl [17] = '{
    6'b010010,                                  // INIT
    6'b101010, 6'b001010, 6'b001010, 6'b001010, // first load, bits 1,0,0,0
    6'b000010,                                  // CAPTURE
    6'b001110, 6'b101110, 6'b101110, 6'b101110, // second load, bits 0,1,1,1
    6'b000010,                                  // CAPTURE
    6'b001110, 6'b001110, 6'b001110, 6'b001110, // UNLOAD
    6'b000010,                                  // CHECK
    6'b000001                                   // DONE
  };
  int exp_pc [17] = '{0,0,0,0,0,0, 1,1,1,1,1, 2,2,2,2,2,2};

  localparam logic [7:0] EXP_BITS = 8'b1000_0111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ctl();
    return {bus.scan_in, bus.misr_reset, bus.scan_enable, bus.misr_enable, bus.busy, bus.done};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic all_zero(input string tag);
    check(tag, {8'h00, ctl(), bus.test_mode, bus.pass, bus.pattern_count}, 32'h0);
  endtask

  // Leaves the bench sampling the INIT cycle.
  task automatic start_session();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic collect_bits(input string tag);
    logic [7:0] bits = '0;
    int         n    = 0;
    for (int i = 0; i < 40 && n < 8; i++) begin
      tick();
      if (bus.scan_enable) begin
        bits = {bits[6:0], bus.scan_in};
        n++;
      end
    end
    check({tag, " count"}, n, 8);
    check({tag, " bits"}, bits, EXP_BITS);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.done && n < 60) begin
      tick();
      n++;
    end
    check(tag, bus.done, 1);
  endtask

  initial begin
    reset             = 1'b1;
    bus.start         = 1'b1;
    bus.abort         = 1'b0;
    bus.pass_nfail_in = 1'b0;

    // T1: reset held with start asserted
    repeat (3) tick();
    all_zero("T1 reset outputs");
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    all_zero("T1 idle after reset");

    // T2 + T4a: full cycle-by-cycle session, passing signature
    bus.pass_nfail_in = 1'b1;
    start_session();
    for (int k = 0; k < 17; k++) begin
      if (k > 0) tick();
      check($sformatf("T2 ctl k=%0d", k), ctl(), exp_ctl[k]);
      check($sformatf("T2 test_mode k=%0d", k), bus.test_mode, exp_ctl[k][1]);
      check($sformatf("T2 pattern_count k=%0d", k), bus.pattern_count, exp_pc[k]);
    end
    check("T4 pass=1", bus.pass, 1);
    tick();
    check("T4 done held", bus.done, 1);
    check("T4 pass held", bus.pass, 1);
    check("T4 pattern_count held", bus.pattern_count, 2);

    // T3 + T4b: restart from DONE, failing signature
    bus.pass_nfail_in = 1'b0;
    start_session();
    check("T4 restart done cleared", bus.done, 0);
    check("T4 restart pass cleared", bus.pass, 0);
    check("T4 restart busy", bus.busy, 1);
    collect_bits("T3");
    wait_done("T4b done");
    check("T4b pass=0", bus.pass, 0);
    check("T4b pattern_count", bus.pattern_count, 2);

    // T5: start ignored mid-SHIFT, reset mid-SHIFT, then fresh session
    start_session();
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("T5 start ignored ctl", ctl(), 6'b001010);
    check("T5 start ignored pc", bus.pattern_count, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    all_zero("T5 reset mid-shift");
    tick();
    all_zero("T5 idle after reset");
    start_session();
    collect_bits("T5 rerun");
    wait_done("T5 done");

    // T6: abort together with start in CAPTURE
    start_session();
    repeat (5) tick();
    check("T6 in capture", ctl(), 6'b000010);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("T6 busy", bus.busy, 0);
    check("T6 done", bus.done, 0);
    all_zero("T6 idle outputs");
    tick();
    all_zero("T6 stays idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
